// File: rtl/instr_block_memory_pkg.sv
// Shared definitions for the block instruction/data memories: word width,
// access FSM states and default access latencies.
package instr_block_memory_pkg;

    localparam int unsigned WORD_BITS    = 32;
    localparam int unsigned IMEM_LATENCY = 40;
    localparam int unsigned DMEM_LATENCY = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/instr_block_memory_byte_ram.sv
// Byte-addressed storage with a synchronous byte write port and a
// combinational block-wide little-endian read at a block index.
module byte_ram
    import instr_block_memory_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS     = 4,
    parameter int unsigned BLOCK_ADDR_BITS = 6,
    parameter int unsigned BYTE_ADDR_BITS  = BLOCK_ADDR_BITS + $clog2(BLOCK_WORDS * 4)
) (
    input  logic                              clk_i,
    input  logic                              we_i,
    input  logic [BYTE_ADDR_BITS-1:0]         waddr_i,
    input  logic [7:0]                        wdata_i,
    input  logic [BLOCK_ADDR_BITS-1:0]        rblock_i,
    output logic [BLOCK_WORDS*WORD_BITS-1:0]  rdata_o
);

    localparam int unsigned BLOCK_BYTES = BLOCK_WORDS * 4;
    localparam int unsigned OFF_BITS    = $clog2(BLOCK_BYTES);
    localparam int unsigned DEPTH       = 2 ** BYTE_ADDR_BITS;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Byte i of the block lands at bits [8i+7:8i], giving little-endian words.
    always_comb begin
        rdata_o = '0;
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
            rdata_o[8*i +: 8] = mem_q[{rblock_i, OFF_BITS'(i)}];
        end
    end

endmodule

// File: rtl/instr_block_memory.sv
// Multi-cycle block memory serving whole cache blocks through a READ/BUSYWAIT
// handshake, with a byte-wide preload port usable in any state.
module instr_block_memory
    import instr_block_memory_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS     = 4,
    parameter int unsigned BLOCK_ADDR_BITS = 6,
    parameter int unsigned LATENCY         = IMEM_LATENCY
) (
    input  logic                                                   CLK,
    input  logic                                                   RESET,
    input  logic                                                   READ,
    input  logic [BLOCK_ADDR_BITS-1:0]                             ADDRESS,
    output logic [BLOCK_WORDS*WORD_BITS-1:0]                       READDATA,
    output logic                                                   BUSYWAIT,
    input  logic                                                   LOAD_EN,
    input  logic [BLOCK_ADDR_BITS+$clog2(BLOCK_WORDS*4)-1:0]       LOAD_ADDR,
    input  logic [7:0]                                             LOAD_DATA
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e                        state_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [BLOCK_ADDR_BITS-1:0]        addr_q;
    logic [BLOCK_WORDS*WORD_BITS-1:0]  rdata_q;
    logic [BLOCK_WORDS*WORD_BITS-1:0]  block_d;

    byte_ram #(
        .BLOCK_WORDS     (BLOCK_WORDS),
        .BLOCK_ADDR_BITS (BLOCK_ADDR_BITS)
    ) u_ram (
        .clk_i    (CLK),
        .we_i     (LOAD_EN),
        .waddr_i  (LOAD_ADDR),
        .wdata_i  (LOAD_DATA),
        .rblock_i (addr_q),
        .rdata_o  (block_d)
    );

    // Capture reads the array before this edge's preload write, so a
    // same-edge write is not seen in the returned block.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (READ) begin
                        addr_q  <= ADDRESS;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rdata_q <= block_d;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // In IDLE the request itself raises BUSYWAIT so the cache stalls at once.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (!RESET) begin
            case (state_q)
                IDLE:    BUSYWAIT = READ;
                BUSY:    BUSYWAIT = 1'b1;
                default: BUSYWAIT = 1'b0;
            endcase
        end
    end

    assign READDATA = rdata_q;

endmodule
